// File: rtl/pool1_relu_maxpool.sv
// pool1_relu_maxpool: streaming ReLU followed by 3x3 stride-2 max-pool.
// Takes an IN_DIM x IN_DIM signed feature map in raster order and emits the
// OUT_DIM x OUT_DIM pooled map in raster order. It uses one horizontal
// running-max register and a row of OUT_DIM vertical accumulators.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake; in_ready = !out_valid || out_ready
//   in_data           signed input pixel
//   out_valid/ready   output handshake; output fields hold until taken
//   out_data          pooled pixel (always >= 0)
//   out_row/out_col   pooled pixel coordinates
//   out_last          marks pooled pixel (OUT_DIM-1, OUT_DIM-1)
module pool1_relu_maxpool #(
   parameter int unsigned IN_DIM  = 55,
   parameter int unsigned OUT_DIM = 27,
   parameter int unsigned DATA_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [4:0]        out_row,
   output logic [4:0]        out_col,
   output logic              out_last
);

   localparam int unsigned CNT_W = $clog2(IN_DIM);
   localparam int unsigned IDX_W = $clog2(OUT_DIM);

   logic [CNT_W-1:0]  r_row, r_col;
   logic [DATA_W-1:0] r_hreg;
   logic [DATA_W-1:0] r_acc [OUT_DIM];
   logic              r_out_valid, r_out_last;
   logic [DATA_W-1:0] r_out_data;
   logic [4:0]        r_out_row, r_out_col;

   logic              w_accept, w_col_end, w_row_end, w_hdone, w_emit;
   logic [DATA_W-1:0] w_x, w_h, w_v;
   logic [IDX_W-1:0]  w_i, w_j;

   assign in_ready  = !r_out_valid || out_ready;
   assign w_accept  = in_valid && in_ready;

   // ReLU: once negatives are zeroed, all maxima are plain unsigned compares
   assign w_x = in_data[DATA_W-1] ? '0 : in_data;
   assign w_h = (r_hreg > w_x) ? r_hreg : w_x;

   assign w_col_end = (r_col == CNT_W'(IN_DIM - 1));
   assign w_row_end = (r_row == CNT_W'(IN_DIM - 1));

   // An even column >= 2 closes a horizontal window; an even row >= 2 closes a vertical one
   assign w_hdone = !r_col[0] && (r_col != '0);
   assign w_emit  = w_accept && w_hdone && !r_row[0] && (r_row != '0);

   // Window index = col/2 - 1 (only meaningful when a window closes)
   assign w_j = IDX_W'((r_col >> 1) - CNT_W'(1));
   assign w_i = IDX_W'((r_row >> 1) - CNT_W'(1));
   assign w_v = (r_acc[w_j] > w_h) ? r_acc[w_j] : w_h;

   // Raster counters and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row       <= '0;
         r_col       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_row   <= '0;
         r_out_col   <= '0;
         r_out_last  <= 1'b0;
      end else begin
         if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            if (w_col_end) begin
               r_col <= '0;
               r_row <= w_row_end ? '0 : r_row + CNT_W'(1);
            end else begin
               r_col <= r_col + CNT_W'(1);
            end
         end
         // A load here overrides the drain above, giving back-to-back transfers
         if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_v;
            r_out_row   <= 5'(w_i);
            r_out_col   <= 5'(w_j);
            r_out_last  <= (w_i == IDX_W'(OUT_DIM - 1)) && (w_j == IDX_W'(OUT_DIM - 1));
         end
      end
   end

   // Running-max datapath; row 0 / column 0 overwrite stale contents, so no reset
   always_ff @(posedge clk) begin
      if (w_accept) begin
         if (r_col == '0) begin
            r_hreg <= w_x;
         end else if (r_col[0]) begin
            r_hreg <= w_h;
         end else begin
            // Shared column: this pixel also opens the next window
            r_hreg <= w_x;
         end
         if (w_hdone) begin
            if (r_row == '0) begin
               r_acc[w_j] <= w_h;
            end else if (r_row[0]) begin
               r_acc[w_j] <= w_v;
            end else begin
               // Shared row: this row also opens the next vertical window
               r_acc[w_j] <= w_h;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_row   = r_out_row;
   assign out_col   = r_out_col;
   assign out_last  = r_out_last;

endmodule

// File: tb/tb_pool1_relu_maxpool.sv
// Bench for pool1_relu_maxpool: directed frames, a table of known pooled
// values, and random frames checked against a direct 3x3 window model.
module tb_pool1_relu_maxpool;

   localparam int IN  = 55;
   localparam int OUT = 27;
   localparam int NPF = IN * IN;
   localparam int OPF = OUT * OUT;
   localparam int MAX_CYC = 40000;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, out_last;
   logic [15:0] in_data, out_data;
   logic [4:0]  out_row, out_col;

   always #5 clk = ~clk;

   pool1_relu_maxpool dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .out_last(out_last)
   );

   typedef struct {
      int test;
      int fr;
      int i;
      int j;
      int exp;
   } vec_t;

   vec_t        tbl[$];
   logic [15:0] img [2*NPF];
   logic [15:0] cap_data[$];
   int          cap_row[$], cap_col[$];
   bit          cap_last[$];
   int          n_cmp = 0, n_bad = 0;
   int          rdy_err, stab_err, rdy_low;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int relu(input logic [15:0] v);
      return v[15] ? 0 : int'(v);
   endfunction

   // Reference: max of the ReLU'd 3x3 window at (2i,2j) of frame f
   function automatic int ref_px(input int f, input int i, input int j);
      int m = 0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            if (relu(img[f*NPF + (2*i+r)*IN + 2*j+c]) > m)
               m = relu(img[f*NPF + (2*i+r)*IN + 2*j+c]);
      return m;
   endfunction

   function automatic void clear_caps();
      cap_data.delete(); cap_row.delete(); cap_col.delete(); cap_last.delete();
   endfunction

   function automatic void fill_ramp(input int f, input int ofs);
      for (int k = 0; k < NPF; k++) img[f*NPF + k] = 16'(k + ofs);
   endfunction

   // Drives npix pixels from img[], captures every output transfer, optionally
   // drains the final output. Starts and ends just after a rising edge.
   task automatic run(input int npix, input bit bp, input bit gaps, input bit drain);
      int idx = 0;
      int cyc = 0;
      bit held = 0;
      logic [15:0] hd;
      logic [4:0] hr, hc;
      logic hl;
      rdy_err = 0; stab_err = 0; rdy_low = 0;
      while ((idx < npix || (drain && out_valid)) && cyc < MAX_CYC) begin
         in_valid  = (idx < npix) && (!gaps || $urandom_range(0, 3) != 0);
         in_data   = (idx < npix) ? img[idx] : 16'h0;
         out_ready = !bp || ($urandom_range(0, 2) != 0);
         #1;
         if (in_ready !== (!out_valid || out_ready)) rdy_err++;
         if (!in_ready) rdy_low++;
         if (held && (out_valid !== 1'b1 || out_data !== hd || out_row !== hr ||
                      out_col !== hc || out_last !== hl)) stab_err++;
         held = out_valid && !out_ready;
         hd = out_data; hr = out_row; hc = out_col; hl = out_last;
         if (out_valid && out_ready) begin
            cap_data.push_back(out_data);
            cap_row.push_back(int'(out_row));
            cap_col.push_back(int'(out_col));
            cap_last.push_back(out_last);
         end
         if (in_valid && in_ready) idx++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("run_within_bound", longint'(cyc < MAX_CYC), 1);
   endtask

   // Compares nf captured frames against the window model and raster order
   task automatic check_frames(input string name, input int nf);
      int n, derr, perr, lerr;
      chk({name, "_count"}, cap_data.size(), nf * OPF);
      n = (cap_data.size() < nf * OPF) ? cap_data.size() : nf * OPF;
      derr = 0; perr = 0; lerr = 0;
      for (int k = 0; k < n; k++) begin
         int f, p;
         f = k / OPF;
         p = k % OPF;
         if (int'(cap_data[k]) != ref_px(f, p / OUT, p % OUT)) derr++;
         if (cap_row[k] != p / OUT || cap_col[k] != p % OUT) perr++;
         if (cap_last[k] != (p == OPF - 1)) lerr++;
      end
      chk({name, "_data_errs"}, derr, 0);
      chk({name, "_pos_errs"}, perr, 0);
      chk({name, "_last_errs"}, lerr, 0);
      chk({name, "_ready_errs"}, rdy_err, 0);
      chk({name, "_stall_errs"}, stab_err, 0);
   endtask

   task automatic apply_table(input int test);
      foreach (tbl[t]) begin
         if (tbl[t].test == test) begin
            int k;
            k = tbl[t].fr * OPF + tbl[t].i * OUT + tbl[t].j;
            chk($sformatf("tbl_t%0d_f%0d_(%0d,%0d)", test, tbl[t].fr, tbl[t].i, tbl[t].j),
                (k < cap_data.size()) ? longint'(cap_data[k]) : -1, tbl[t].exp);
         end
      end
   endtask

   initial begin
      tbl = '{
         '{0, 0, 0, 0, 112},  '{0, 0, 0, 26, 164}, '{0, 0, 26, 0, 2972},
         '{0, 0, 26, 26, 3024}, '{0, 0, 13, 7, 1556},
         '{1, 0, 0, 0, 0},    '{1, 0, 26, 26, 0},
         '{2, 0, 0, 0, 1000}, '{2, 0, 0, 1, 1000}, '{2, 0, 1, 0, 1000},
         '{2, 0, 1, 1, 1000}, '{2, 0, 0, 2, 0},    '{2, 0, 2, 1, 0},
         '{3, 0, 0, 0, 112},  '{3, 0, 26, 26, 3024},
         '{4, 0, 0, 0, 112},  '{4, 0, 26, 26, 3024},
         '{6, 0, 0, 0, 112},  '{6, 1, 0, 0, 113},  '{6, 1, 26, 26, 3025}
      };

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_out_rowcol", {out_row, out_col}, 0);
      chk("reset_out_last", out_last, 0);
      chk("reset_in_ready", in_ready, 1);
      rst = 1'b0;

      // Ramp frame, no backpressure
      fill_ramp(0, 0);
      clear_caps();
      run(NPF, 0, 0, 1);
      check_frames("ramp", 1);
      chk("ramp_in_ready_low_cycles", rdy_low, 0);
      apply_table(0);

      // All-negative frame
      for (int k = 0; k < NPF; k++) img[k] = 16'hFFFB;
      clear_caps();
      run(NPF, 0, 0, 1);
      check_frames("neg", 1);
      apply_table(1);

      // Single spike at (2,2)
      for (int k = 0; k < NPF; k++) img[k] = 16'h0;
      img[2*IN + 2] = 16'd1000;
      clear_caps();
      run(NPF, 0, 0, 1);
      check_frames("spike", 1);
      apply_table(2);

      // Ramp under random backpressure and input gaps
      fill_ramp(0, 0);
      clear_caps();
      run(NPF, 1, 1, 1);
      check_frames("bp_ramp", 1);
      apply_table(3);

      // Abandon a frame after 1500 pixels, then a clean ramp frame
      clear_caps();
      run(1500, 1, 0, 0);
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midreset_out_valid", out_valid, 0);
      clear_caps();
      run(NPF, 0, 0, 1);
      check_frames("post_reset", 1);
      apply_table(4);

      // Random signed frame under backpressure
      for (int k = 0; k < NPF; k++) img[k] = 16'($urandom_range(0, 65535));
      clear_caps();
      run(NPF, 1, 1, 1);
      check_frames("random", 1);

      // Two back-to-back frames: ramp then ramp+1
      fill_ramp(0, 0);
      fill_ramp(1, 1);
      clear_caps();
      run(2 * NPF, 0, 0, 1);
      check_frames("b2b", 2);
      apply_table(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pool1_relu_maxpool.md
Name: pool1_relu_maxpool

Overview:
- Streaming ReLU + 3x3 stride-2 max-pool stage directly downstream of the conv1 stage.
- Consumes one 55x55 conv1 feature map in raster order, one pixel per accepted beat, and produces the 27x27 pooled map in raster order.
- Uses one horizontal running-max register and a 27-entry vertical accumulator row, so no full-frame buffering is needed.
- One instance per feature map; 96 instances or time-multiplexed frames build the 27x27x96 volume.

Parameters:
- IN_DIM, 55, input frame height and width; must be odd and >= 3.
- OUT_DIM, 27, output height and width; must equal (IN_DIM-3)/2+1.
- DATA_W, 16, pixel width, two's-complement signed.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream pixel valid.
- in_ready  out  1  stage can accept a pixel.
- in_data  in  DATA_W  signed conv1 pixel.
- out_valid  out  1  pooled pixel valid.
- out_ready  in  1  downstream accepts the pooled pixel.
- out_data  out  DATA_W  pooled pixel, always >= 0.
- out_row  out  5  output row index 0..OUT_DIM-1.
- out_col  out  5  output column index 0..OUT_DIM-1.
- out_last  out  1  high with the final pixel (26,26) of a frame.

Behaviour:
- Reset (synchronous, rst high at a clk edge) clears the following: row/col counters, out_valid, out_data, out_row, out_col and out_last. The accumulator contents are don't-care because row 0 overwrites them. Reset mid-frame abandons the frame; the next accepted pixel is (0,0).
- Accept condition: in_valid && in_ready. in_ready = !out_valid || out_ready, combinational and independent of in_valid.
- ReLU: x = (in_data < 0) ? 0 : in_data. It is applied before any max. All comparisons are unsigned on the ReLU'd values.
- Counters: col increments per accepted pixel. At col==IN_DIM-1 it wraps to 0 and row increments. At row==IN_DIM-1 and col==IN_DIM-1, both wrap to 0 (next frame).
- Horizontal max register hreg, updated on accept:
  - col==0: hreg<=x.
  - col odd: hreg<=max(hreg,x).
  - col even and >=2: h=max(hreg,x) completes column window j=(col-2)/2; hreg<=x because the shared column starts the next window.
- Vertical accumulator acc[0..OUT_DIM-1], updated only when h completes:
  - row==0: acc[j]<=h.
  - row odd: acc[j]<=max(acc[j],h).
  - row even and >=2: result=max(acc[j],h) is emitted as pixel (i=(row-2)/2, j). acc[j]<=h, because the shared row starts the next window.
- Output register: loaded on the same edge that accepts the completing pixel, giving latency 1 cycle from accept to out_valid.
  - out_valid, out_data, out_row, out_col and out_last hold stable until out_valid && out_ready.
  - A new load and the drain of the current pixel may occur on the same edge (back-to-back).
- out_last=1 only for i=OUT_DIM-1, j=OUT_DIM-1.
- Each frame yields exactly OUT_DIM*OUT_DIM outputs (729 at defaults).
- Pixels that complete no window still require in_ready.
- No overflow is possible; widths are preserved with no saturation or rounding.
- Throughput: 1 pixel/cycle with out_ready held high.

Test Plan:
- Ramp: in_data = row*55+col, out_ready=1. Require out_data(i,j) = (2i+2)*55+(2j+2), e.g. (0,0)=112 and (26,26)=3024. Require 729 outputs, out_last only on the last, and in_ready constantly 1.
- All-negative frame (every pixel -5, i.e. 16'hFFFB): require all 729 outputs = 0.
- Single spike: 1000 at input (2,2), all other pixels 0. Require outputs (0,0), (0,1), (1,0), (1,1) = 1000 (shared row/column overlap) and every other output 0.
- Backpressure: ramp frame with out_ready toggling on a pseudo-random pattern. Require in_ready to drop only while out_valid && !out_ready, outputs to be identical to the first test, and held data to stay stable while stalled.
- Reset mid-frame: rst asserted after 1500 accepted pixels, then a full ramp frame. Require out_valid low the cycle after reset, then exactly 729 correct outputs starting at (0,0)=112.
- Two back-to-back frames (ramp, then ramp+1): require the second frame's (0,0)=113, with no stale accumulator data carried between frames.
